l2_cache_ctrl: RTL and testbench

- 2-way set-associative, write-back, write-allocate L2 cache with 256-bit lines.
- Sits directly upstream of eviction_write_buffer:
  - serves line requests from the L1 side;
  - issues victim writebacks and line fills on the ewb_mem_* interface.
- The EWB acknowledges writebacks immediately, so a dirty miss normally costs one extra cycle before the fill read.

---
 rtl/l2_cache_ctrl_if.sv | 26 ++
 rtl/l2_cache_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_l2_cache_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_cache_ctrl_if.sv
// Line-request bus from L1 and victim/fill bus toward the eviction write buffer.
// The controller uses the slave view; the environment (L1 + EWB) uses the master view.
interface l2_cache_ctrl_if;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         ewb_mem_read;
    logic         ewb_mem_write;
    logic [15:0]  ewb_mem_address;
    logic [255:0] ewb_mem_wdata;
    logic [255:0] ewb_mem_rdata;
    logic         ewb_mem_resp;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, ewb_mem_rdata, ewb_mem_resp,
        output mem_rdata, mem_resp, ewb_mem_read, ewb_mem_write, ewb_mem_address, ewb_mem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, ewb_mem_rdata, ewb_mem_resp,
        input  mem_rdata, mem_resp, ewb_mem_read, ewb_mem_write, ewb_mem_address, ewb_mem_wdata
    );
endinterface

// File: rtl/l2_cache_ctrl.sv
// 2-way set-associative, write-back, write-allocate L2 controller with 256-bit lines.
// Define L2_PERF_COUNTERS_EN to build the saturating hit/miss/writeback counters.
module l2_cache_ctrl #(
    parameter int NUM_SETS = 8
) (
    input  logic           clk,
    input  logic           reset,
    l2_cache_ctrl_if.slave bus,
    output logic [15:0]    hit_count,
    output logic [15:0]    miss_count,
    output logic [15:0]    wb_count
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 11 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t                   state_q, state_d;
    logic [NUM_SETS-1:0][1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0][1:0] dirty_q, dirty_d;
    logic [NUM_SETS-1:0]      lru_q, lru_d;
    logic [TAG_W-1:0]         tag_q  [NUM_SETS][2];
    logic [TAG_W-1:0]         tag_d  [NUM_SETS][2];
    logic [255:0]             data_q [NUM_SETS][2];
    logic [255:0]             data_d [NUM_SETS][2];

    logic [IDX_W-1:0] vic_idx_q, vic_idx_d;
    logic             vic_way_q, vic_way_d;
    logic [TAG_W-1:0] req_tag_q, req_tag_d;
    logic             ewb_rd_q, ewb_rd_d;
    logic             ewb_wr_q, ewb_wr_d;
    logic [15:0]      ewb_addr_q, ewb_addr_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             req, hit0, hit1, hit, hit_way;
    logic             idle_hit, idle_miss, vic_way, vic_dirty, wb_done, fill_done;
    logic             unused_addr_bits;

    assign req_tag          = bus.mem_address[15:5+IDX_W];
    assign req_idx          = bus.mem_address[4+IDX_W:5];
    assign unused_addr_bits = ^bus.mem_address[4:0];

    always_comb begin
        req       = bus.mem_read | bus.mem_write;
        hit0      = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
        hit1      = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
        hit       = hit0 | hit1;
        hit_way   = hit1 & ~hit0;
        idle_hit  = !reset && (state_q == IDLE) && req && hit;
        idle_miss = !reset && (state_q == IDLE) && req && !hit;
        // Fill empty ways first (way0 before way1); only evict by LRU once the set is full.
        if (!valid_q[req_idx][0])      vic_way = 1'b0;
        else if (!valid_q[req_idx][1]) vic_way = 1'b1;
        else                           vic_way = lru_q[req_idx];
        vic_dirty = valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way];
        wb_done   = (state_q == WRITEBACK) && bus.ewb_mem_resp;
        fill_done = (state_q == FILL) && bus.ewb_mem_resp;
    end

    assign bus.mem_resp        = idle_hit;
    assign bus.mem_rdata       = idle_hit ? data_q[req_idx][hit_way] : '0;
    assign bus.ewb_mem_read    = ewb_rd_q;
    assign bus.ewb_mem_write   = ewb_wr_q;
    assign bus.ewb_mem_address = ewb_addr_q;
    assign bus.ewb_mem_wdata   = ewb_wr_q ? data_q[vic_idx_q][vic_way_q] : '0;

    // Controller next state; strobes and address are registered so they hold steady per state.
    always_comb begin
        state_d    = state_q;
        vic_idx_d  = vic_idx_q;
        vic_way_d  = vic_way_q;
        req_tag_d  = req_tag_q;
        ewb_rd_d   = ewb_rd_q;
        ewb_wr_d   = ewb_wr_q;
        ewb_addr_d = ewb_addr_q;
        case (state_q)
            IDLE: begin
                if (idle_miss) begin
                    vic_idx_d = req_idx;
                    vic_way_d = vic_way;
                    req_tag_d = req_tag;
                    if (vic_dirty) begin
                        state_d    = WRITEBACK;
                        ewb_wr_d   = 1'b1;
                        ewb_addr_d = {tag_q[req_idx][vic_way], req_idx, 5'b0};
                    end else begin
                        state_d    = FILL;
                        ewb_rd_d   = 1'b1;
                        ewb_addr_d = {req_tag, req_idx, 5'b0};
                    end
                end
            end
            WRITEBACK: begin
                if (bus.ewb_mem_resp) begin
                    state_d    = FILL;
                    ewb_wr_d   = 1'b0;
                    ewb_rd_d   = 1'b1;
                    ewb_addr_d = {req_tag_q, vic_idx_q, 5'b0};
                end
            end
            FILL: begin
                if (bus.ewb_mem_resp) begin
                    state_d    = IDLE;
                    ewb_rd_d   = 1'b0;
                    ewb_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            vic_idx_q  <= '0;
            vic_way_q  <= 1'b0;
            req_tag_q  <= '0;
            ewb_rd_q   <= 1'b0;
            ewb_wr_q   <= 1'b0;
            ewb_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            vic_idx_q  <= vic_idx_d;
            vic_way_q  <= vic_way_d;
            req_tag_q  <= req_tag_d;
            ewb_rd_q   <= ewb_rd_d;
            ewb_wr_q   <= ewb_wr_d;
            ewb_addr_q <= ewb_addr_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        lru_d   = lru_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (idle_hit) begin
            lru_d[req_idx] = ~hit_way;
            if (bus.mem_write) begin
                data_d[req_idx][hit_way]  = bus.mem_wdata;
                dirty_d[req_idx][hit_way] = 1'b1;
            end
        end
        if (wb_done) dirty_d[vic_idx_q][vic_way_q] = 1'b0;
        if (fill_done) begin
            data_d[vic_idx_q][vic_way_q]  = bus.ewb_mem_rdata;
            tag_d[vic_idx_q][vic_way_q]   = req_tag_q;
            valid_d[vic_idx_q][vic_way_q] = 1'b1;
            dirty_d[vic_idx_q][vic_way_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            lru_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            lru_q   <= lru_d;
        end
    end

    // Tags and line data need no reset: nothing is visible until its valid bit is set.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef L2_PERF_COUNTERS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (idle_hit  && hit_cnt_q  != 16'hFFFF) hit_cnt_d  = hit_cnt_q + 16'd1;
        if (idle_miss && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        if (wb_done   && wb_cnt_q   != 16'hFFFF) wb_cnt_d   = wb_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
    assign wb_count   = 16'd0;
`endif
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Bench for l2_cache_ctrl: acts as L1 and as the EWB, and predicts behaviour from a
// line-level memory image plus a per-set valid/dirty/tag/LRU picture of the cache.
module tb_l2_cache_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l2_cache_ctrl_if bus();
    logic [15:0] hit_count, miss_count, wb_count;

    l2_cache_ctrl #(.NUM_SETS(8)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

`ifdef L2_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] backing [logic [15:0]];   // contents held by the EWB / memory
    logic [255:0] gold    [logic [15:0]];   // what L1 should observe for each line

    bit       mv [8][2];
    bit       md [8][2];
    logic [7:0] mt [8][2];
    bit       ml [8];

    typedef struct {
        logic [255:0] rd;
        int           cyc;
        int           nwb;
        logic [15:0]  wba;
        logic [255:0] wbd;
        int           nfill;
        logic [15:0]  fa;
        bit           to;
        bit           both;
    } res_t;

    function automatic logic [255:0] init_line(input logic [15:0] la);
        return {8{la, ~la}};
    endfunction

    function automatic logic [255:0] back_rd(input logic [15:0] la);
        return backing.exists(la) ? backing[la] : init_line(la);
    endfunction

    function automatic logic [255:0] gold_rd(input logic [15:0] la);
        return gold.exists(la) ? gold[la] : init_line(la);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.ewb_mem_resp = 1'b0; bus.ewb_mem_rdata = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one L1 request and play the EWB with a fixed response latency.
    task automatic do_req(input bit wr, input logic [15:0] a, input logic [255:0] wd,
                          input int lat, output res_t r);
        int wcnt;
        wcnt = 0;
        r = '{rd: '0, cyc: 0, nwb: 0, wba: '0, wbd: '0, nfill: 0, fa: '0, to: 1'b1, both: 1'b0};
        @(negedge clk);
        bus.mem_read = !wr; bus.mem_write = wr; bus.mem_address = a; bus.mem_wdata = wd;
        for (int i = 0; i < 300; i++) begin
            #1;
            bus.ewb_mem_resp = 1'b0;
            bus.ewb_mem_rdata = '0;
            if (bus.ewb_mem_read && bus.ewb_mem_write) r.both = 1'b1;
            if (bus.mem_resp) begin
                r.rd = bus.mem_rdata;
                r.to = 1'b0;
                break;
            end
            if (bus.ewb_mem_write || bus.ewb_mem_read) begin
                if (wcnt >= lat) begin
                    wcnt = 0;
                    bus.ewb_mem_resp = 1'b1;
                    if (bus.ewb_mem_write) begin
                        backing[bus.ewb_mem_address] = bus.ewb_mem_wdata;
                        r.nwb++; r.wba = bus.ewb_mem_address; r.wbd = bus.ewb_mem_wdata;
                    end else begin
                        bus.ewb_mem_rdata = back_rd(bus.ewb_mem_address);
                        r.nfill++; r.fa = bus.ewb_mem_address;
                    end
                end else wcnt++;
            end
            @(negedge clk);
            r.cyc++;
        end
        @(posedge clk); #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.ewb_mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.ewb_mem_resp = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if ({bus.mem_resp, bus.ewb_mem_read, bus.ewb_mem_write} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b exp 000", {bus.mem_resp, bus.ewb_mem_read, bus.ewb_mem_write}); end
        n_checks++; if (bus.ewb_mem_address !== 16'h0) begin
            n_fail++; $display("FAIL reset_ewb_addr: got %h exp 0000", bus.ewb_mem_address); end
        n_checks++; if ({hit_count, miss_count, wb_count} !== 48'h0) begin
            n_fail++; $display("FAIL reset_counters: got %h/%h/%h exp 0", hit_count, miss_count, wb_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_cold_read_miss();
        res_t r;
        logic [255:0] good;
        good = {16{16'h600d}};
        apply_reset();
        backing[16'h0020] = good;
        do_req(1'b0, 16'h0020, '0, 0, r);
        n_checks++; if (r.to !== 1'b0) begin n_fail++; $display("FAIL cold_timeout: got %0d exp 0", r.to); end
        n_checks++; if (r.nfill !== 1 || r.fa !== 16'h0020) begin
            n_fail++; $display("FAIL cold_fill: got %0d fills addr %h exp 1 addr 0020", r.nfill, r.fa); end
        n_checks++; if (r.cyc !== 2) begin n_fail++; $display("FAIL cold_latency: got %0d exp 2", r.cyc); end
        n_checks++; if (r.rd !== good) begin n_fail++; $display("FAIL cold_rdata: got %h exp %h", r.rd, good); end
        n_checks++; if (hit_count !== (PERF ? 16'd1 : 16'd0) || miss_count !== (PERF ? 16'd1 : 16'd0)) begin
            n_fail++; $display("FAIL cold_counters: got hit %0d miss %0d", hit_count, miss_count); end
    endtask

    task automatic test_write_hit_evict();
        res_t r;
        logic [255:0] bad;
        bad = {16{16'hbaad}};
        apply_reset();
        backing.delete();
        do_req(1'b0, 16'h0020, '0, 0, r);
        do_req(1'b1, 16'h0020, bad, 0, r);
        n_checks++; if (r.cyc !== 0 || r.to) begin n_fail++; $display("FAIL whit_zero_wait: got %0d cycles exp 0", r.cyc); end
        do_req(1'b0, 16'h0120, '0, 0, r);
        n_checks++; if (r.nwb !== 0 || r.nfill !== 1) begin
            n_fail++; $display("FAIL whit_second_miss: got wb %0d fill %0d exp 0/1", r.nwb, r.nfill); end
        do_req(1'b0, 16'h0220, '0, 0, r);
        n_checks++; if (r.nwb !== 1 || r.wba !== 16'h0020) begin
            n_fail++; $display("FAIL evict_wb_addr: got %0d wbs addr %h exp 1 addr 0020", r.nwb, r.wba); end
        n_checks++; if (r.wbd !== bad) begin n_fail++; $display("FAIL evict_wb_data: got %h exp %h", r.wbd, bad); end
        n_checks++; if (r.fa !== 16'h0220 || r.cyc !== 3 || r.both) begin
            n_fail++; $display("FAIL evict_fill: got addr %h cyc %0d both %0d exp 0220/3/0", r.fa, r.cyc, r.both); end
        n_checks++; if (wb_count !== (PERF ? 16'd1 : 16'd0) || hit_count !== (PERF ? 16'd4 : 16'd0)
                        || miss_count !== (PERF ? 16'd3 : 16'd0)) begin
            n_fail++; $display("FAIL evict_counters: got hit %0d miss %0d wb %0d", hit_count, miss_count, wb_count); end
        do_req(1'b0, 16'h0020, '0, 1, r);
        n_checks++; if (r.rd !== bad || r.nwb !== 0) begin
            n_fail++; $display("FAIL evict_refetch: got %h wb %0d exp %h wb 0", r.rd, r.nwb, bad); end
    endtask

    task automatic test_lru();
        res_t r;
        apply_reset();
        do_req(1'b0, 16'h0040, '0, 0, r);
        do_req(1'b0, 16'h0140, '0, 0, r);
        do_req(1'b0, 16'h0040, '0, 0, r);
        do_req(1'b0, 16'h0240, '0, 0, r);
        n_checks++; if (r.nwb !== 0 || r.nfill !== 1 || r.fa !== 16'h0240) begin
            n_fail++; $display("FAIL lru_replace: got wb %0d fill %0d addr %h exp 0/1/0240", r.nwb, r.nfill, r.fa); end
        do_req(1'b0, 16'h0040, '0, 0, r);
        n_checks++; if (r.cyc !== 0 || r.nfill !== 0) begin
            n_fail++; $display("FAIL lru_mru_kept: got cyc %0d fill %0d exp 0/0", r.cyc, r.nfill); end
        do_req(1'b0, 16'h0140, '0, 0, r);
        n_checks++; if (r.nfill !== 1) begin n_fail++; $display("FAIL lru_evicted_gone: got fill %0d exp 1", r.nfill); end
    endtask

    task automatic test_slow_ewb();
        int bad;
        logic [255:0] fd;
        fd = {8{32'hc0ffee11}};
        bad = 0;
        apply_reset();
        @(negedge clk);
        bus.mem_read = 1'b1; bus.mem_address = 16'h0060;
        @(negedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            if (!bus.ewb_mem_read || bus.ewb_mem_address !== 16'h0060 || bus.mem_resp || bus.ewb_mem_write) bad++;
            @(negedge clk); #1;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL slow_hold: got %0d unstable cycles exp 0", bad); end
        bus.ewb_mem_resp = 1'b1; bus.ewb_mem_rdata = fd;
        @(negedge clk); #1;
        bus.ewb_mem_resp = 1'b0; bus.ewb_mem_rdata = '0;
        n_checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== fd || bus.ewb_mem_read !== 1'b0) begin
            n_fail++; $display("FAIL slow_complete: got resp %b rd %b data %h exp 1/0/%h",
                               bus.mem_resp, bus.ewb_mem_read, bus.mem_rdata, fd); end
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
    endtask

    task automatic test_reset_mid_wb();
        res_t r;
        apply_reset();
        backing.delete();
        do_req(1'b0, 16'h0020, '0, 0, r);
        do_req(1'b1, 16'h0020, {8{32'h12345678}}, 0, r);
        do_req(1'b0, 16'h0120, '0, 0, r);
        @(negedge clk);
        bus.mem_read = 1'b1; bus.mem_address = 16'h0220;
        @(negedge clk); #1;
        n_checks++; if (bus.ewb_mem_write !== 1'b1 || bus.ewb_mem_address !== 16'h0020) begin
            n_fail++; $display("FAIL rstwb_enter: got wr %b addr %h exp 1/0020", bus.ewb_mem_write, bus.ewb_mem_address); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({bus.ewb_mem_write, bus.ewb_mem_read, bus.mem_resp} !== 3'b000
                        || bus.ewb_mem_wdata !== '0 || bus.ewb_mem_address !== 16'h0) begin
            n_fail++; $display("FAIL rstwb_outputs: got %b addr %h exp 000 addr 0000",
                               {bus.ewb_mem_write, bus.ewb_mem_read, bus.mem_resp}, bus.ewb_mem_address); end
        reset = 1'b0; bus.mem_read = 1'b0;
        do_req(1'b0, 16'h0020, '0, 0, r);
        n_checks++; if (r.nfill !== 1 || r.cyc !== 2 || r.rd !== init_line(16'h0020)) begin
            n_fail++; $display("FAIL rstwb_cold_again: got fill %0d cyc %0d data %h exp 1/2/%h",
                               r.nfill, r.cyc, r.rd, init_line(16'h0020)); end
    endtask

    task automatic test_random();
        res_t r;
        logic [7:0] tg;
        logic [2:0] ix;
        logic [4:0] lo;
        logic [15:0] a, la, exp_wba;
        logic [255:0] wd;
        bit wr, dirty, hit;
        int lat, vw, hw, exp_cyc, errs;
        errs = 0;
        apply_reset();
        backing.delete();
        gold.delete();
        for (int s = 0; s < 8; s++) begin
            ml[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin mv[s][w] = 1'b0; md[s][w] = 1'b0; mt[s][w] = '0; end
        end
        for (int n = 0; n < 250; n++) begin
            tg = 8'($urandom_range(0, 3));
            ix = 3'($urandom_range(0, 7));
            lo = 5'($urandom_range(0, 31));
            a  = {tg, ix, lo};
            la = {tg, ix, 5'b0};
            wr = ($urandom_range(0, 2) == 0);
            wd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            lat = $urandom_range(0, 3);
            hit = 1'b0; hw = 0; dirty = 1'b0; exp_wba = '0; exp_cyc = 0;
            for (int w = 0; w < 2; w++) if (mv[ix][w] && mt[ix][w] == tg) begin hit = 1'b1; hw = w; end
            if (!hit) begin
                vw = !mv[ix][0] ? 0 : (!mv[ix][1] ? 1 : int'(ml[ix]));
                dirty = mv[ix][vw] && md[ix][vw];
                exp_wba = {mt[ix][vw], ix, 5'b0};
                exp_cyc = dirty ? 3 + 2 * lat : 2 + lat;
                mv[ix][vw] = 1'b1; md[ix][vw] = 1'b0; mt[ix][vw] = tg;
                hw = vw;
            end
            do_req(wr, a, wd, lat, r);
            n_checks++; if (r.to || r.cyc !== exp_cyc || r.both) begin
                n_fail++; errs++;
                $display("FAIL rand_latency[%0d]: got cyc %0d to %0d both %0d exp cyc %0d", n, r.cyc, r.to, r.both, exp_cyc); end
            n_checks++; if (r.nwb !== int'(dirty) || (dirty && (r.wba !== exp_wba || r.wbd !== gold_rd(exp_wba)))) begin
                n_fail++; errs++;
                $display("FAIL rand_writeback[%0d]: got %0d wbs addr %h exp %0d addr %h", n, r.nwb, r.wba, dirty, exp_wba); end
            n_checks++; if (r.nfill !== int'(!hit) || (!hit && r.fa !== la)) begin
                n_fail++; errs++;
                $display("FAIL rand_fill[%0d]: got %0d fills addr %h exp %0d addr %h", n, r.nfill, r.fa, !hit, la); end
            if (!wr) begin
                n_checks++; if (r.rd !== gold_rd(la)) begin
                    n_fail++; errs++;
                    $display("FAIL rand_rdata[%0d]: got %h exp %h", n, r.rd, gold_rd(la)); end
            end
            ml[ix] = (hw == 0);
            if (wr) begin md[ix][hw] = 1'b1; gold[la] = wd; end
            if (errs > 8) break;
        end
    endtask

    task automatic test_counter_saturation();
        res_t r;
        apply_reset();
        do_req(1'b0, 16'h0080, '0, 0, r);
        @(negedge clk);
        bus.mem_read = 1'b1; bus.mem_address = 16'h0080;
        repeat (65540) @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        n_checks++; if (hit_count !== (PERF ? 16'hFFFF : 16'h0)) begin
            n_fail++; $display("FAIL sat_hit_count: got %h exp %h", hit_count, PERF ? 16'hFFFF : 16'h0); end
        n_checks++; if (miss_count !== (PERF ? 16'd1 : 16'd0) || wb_count !== 16'd0) begin
            n_fail++; $display("FAIL sat_other_counts: got miss %0d wb %0d", miss_count, wb_count); end
    endtask

    initial begin
        reset = 1'b1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.mem_address = '0; bus.mem_wdata = '0;
        bus.ewb_mem_resp = 1'b0; bus.ewb_mem_rdata = '0;
        test_reset();
        test_cold_read_miss();
        test_write_hit_evict();
        test_lru();
        test_slow_ewb();
        test_reset_mid_wb();
        test_random();
        test_counter_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
